// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler
//   Shares a single spi_master between NREQ requesters. A round-robin arbiter
//   picks a requester, captures its frame onto din, and holds newd high until
//   the master answers by pulling cs low. The transaction completes when cs
//   returns high. A per-phase watchdog aborts a transaction whose master never
//   starts (LAUNCH) or never ends (XFER) the frame.
//
// Ports
//   clk       in   system clock, shared with spi_master
//   rst       in   asynchronous active-low reset
//   req       in   [NREQ]     request level per requester, held until gnt
//   req_data  in   [NREQ*DW]  frame for requester i at [i*DW +: DW]
//   gnt       out  [NREQ]     one-cycle pulse, request accepted and data captured
//   cmpl      out  [NREQ]     one-cycle pulse, frame finished on the bus
//   err       out             one-cycle pulse, watchdog abort
//   err_id    out  [log2 NREQ] requester id of the aborted transaction
//   busy      out             high whenever a transaction is in progress
//   newd      out             to spi_master newd
//   din       out  [DW]       to spi_master din, stable from gnt until next grant
//   cs        in              spi_master frame strobe (active low, sclk domain)

module spi_txn_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         cmpl,
  output logic                    err,
  output logic [$clog2(NREQ)-1:0] err_id,
  output logic                    busy,
  output logic                    newd,
  output logic [DW-1:0]           din,
  input  logic                    cs
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] XFER   = 2'd2;

  localparam logic [TW-1:0]   TMAX   = TW'(TIMEOUT);
  localparam logic [NREQ-1:0] ONEHOT = NREQ'(1);

  logic [1:0]     state_r;
  logic [TW-1:0]  timer_r;
  logic [IDW-1:0] rr_ptr_r;
  logic [IDW-1:0] id_r;
  logic [1:0]     cs_sync_r;
  logic           cs_s;
  logic           any_s;
  logic [IDW-1:0] win_s;
  logic [IDW-1:0] sel_s;
  int             idx_s;

  // cs crosses from the sclk domain; the FSM only ever looks at the second flop.
  assign cs_s = cs_sync_r[1];
  assign busy = (state_r != IDLE);

  // Round-robin search: first active request after the last winner, wrapping.
  always_comb begin
    any_s = 1'b0;
    win_s = '0;
    sel_s = '0;
    idx_s = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = (int'(rr_ptr_r) + k) % NREQ;
      sel_s = idx_s[IDW-1:0];
      if (!any_s && req[sel_s]) begin
        any_s = 1'b1;
        win_s = sel_s;
      end else begin
        any_s = any_s;
      end
    end
  end

  // cs resynchroniser; idles high so a reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync_r <= 2'b11;
    end else begin
      cs_sync_r <= {cs_sync_r[0], cs};
    end
  end

  // Transaction FSM with registered pulse outputs and phase watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      timer_r  <= '0;
      rr_ptr_r <= IDW'(NREQ - 1);
      id_r     <= '0;
      gnt      <= '0;
      cmpl     <= '0;
      err      <= 1'b0;
      err_id   <= '0;
      newd     <= 1'b0;
      din      <= '0;
    end else begin
      gnt  <= '0;
      cmpl <= '0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            gnt      <= ONEHOT << win_s;
            din      <= req_data[int'(win_s)*DW +: DW];
            id_r     <= win_s;
            rr_ptr_r <= win_s;
            newd     <= 1'b1;
            timer_r  <= '0;
            state_r  <= LAUNCH;
          end else begin
            state_r <= IDLE;
          end
        end
        LAUNCH: begin
          // A cs edge arriving on the timeout cycle still counts as progress.
          if (!cs_s) begin
            newd    <= 1'b0;
            timer_r <= '0;
            state_r <= XFER;
          end else if (timer_r == TMAX) begin
            newd    <= 1'b0;
            err     <= 1'b1;
            err_id  <= id_r;
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        XFER: begin
          if (cs_s) begin
            cmpl    <= ONEHOT << id_r;
            state_r <= IDLE;
          end else if (timer_r == TMAX) begin
            err     <= 1'b1;
            err_id  <= id_r;
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          newd    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Self-checking bench for spi_txn_scheduler. The bench plays the spi_master:
// it watches newd, pulls cs low after a chosen delay and releases it after a
// chosen frame length. Expected grants come from a rotating-priority list model.
module tb_spi_txn_scheduler;

  localparam int NREQ    = 4;
  localparam int DW      = 12;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   cmpl;
  logic              err;
  logic [1:0]        err_id;
  logic              busy;
  logic              newd;
  logic [DW-1:0]     din;
  logic              cs;

  logic [DW-1:0]     dat [NREQ];
  int                vectors = 0;
  int                miscompares = 0;
  int                last_id;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  spi_txn_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .cmpl(cmpl), .err(err), .err_id(err_id),
    .busy(busy), .newd(newd), .din(din), .cs(cs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Priority list starts just after the previous winner; first requester in it wins.
  function automatic int model_winner(input logic [NREQ-1:0] mask, input int last);
    int order[$];
    for (int i = 0; i < NREQ; i++) order.push_back(i);
    repeat (last + 1) order.push_back(order.pop_front());
    foreach (order[j]) if (mask[order[j]]) return order[j];
    return 0;
  endfunction

  task automatic do_reset;
    rst = 1'b0;
    cs  = 1'b1;
    req = '0;
    tick;
    tick;
    rst = 1'b1;
    last_id = NREQ - 1;
    tick;
  endtask

  // One complete transaction: d = negedges between gnt and cs low,
  // t = negedges cs stays low (3..17).
  task automatic do_txn(input int d, input int t, input logic [NREQ-1:0] raise, input bit keep);
    int w;
    logic [DW-1:0] ed;
    bit ok;
    w  = model_winner(req, last_id);
    ed = dat[w];
    tick;
    chk("gnt", 32'(gnt), 32'(1 << w));
    chk("din_at_gnt", 32'(din), 32'(ed));
    chk("newd_at_gnt", 32'(newd), 32'd1);
    chk("busy_at_gnt", 32'(busy), 32'd1);
    if (!keep) req[w[1:0]] = 1'b0;
    dat[w] = 12'($urandom);
    req = req | raise;
    ok = 1'b1;
    repeat (d) begin
      tick;
      if (newd !== 1'b1 || gnt !== '0 || err !== 1'b0) ok = 1'b0;
    end
    cs = 1'b0;
    tick;
    tick;
    if (newd !== 1'b1 || err !== 1'b0) ok = 1'b0;
    chk("newd_held_launch", 32'(ok), 32'd1);
    tick;
    chk("newd_drop_xfer", 32'(newd), 32'd0);
    chk("busy_xfer", 32'(busy), 32'd1);
    ok = 1'b1;
    repeat (t - 3) begin
      tick;
      if (cmpl !== '0 || err !== 1'b0 || gnt !== '0 || newd !== 1'b0 || din !== ed) ok = 1'b0;
    end
    cs = 1'b1;
    tick;
    tick;
    if (cmpl !== '0 || err !== 1'b0 || din !== ed) ok = 1'b0;
    chk("xfer_quiet", 32'(ok), 32'd1);
    tick;
    chk("cmpl", 32'(cmpl), 32'(1 << w));
    chk("no_err_on_cmpl", 32'(err), 32'd0);
    chk("busy_after_cmpl", 32'(busy), 32'd0);
    chk("din_after_cmpl", 32'(din), 32'(ed));
    last_id = w;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [DW-1:0] ed;
    bit ok;

    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    rst = 1'b0;
    req = '0;
    cs  = 1'b1;
    last_id = NREQ - 1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_cmpl", 32'(cmpl), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_id", 32'(err_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_newd", 32'(newd), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    tick;
    tick;
    rst = 1'b1;
    tick;

    // Single request from reset.
    dat[0] = 12'hA5C;
    req = 4'b0001;
    do_txn(2, 5, 4'b0000, 1'b0);

    // Two simultaneous requests; second grant directly follows the first cmpl.
    do_reset;
    dat[0] = 12'h111;
    dat[2] = 12'h222;
    req = 4'b0101;
    do_txn(1, 4, 4'b0000, 1'b0);
    do_txn(3, 6, 4'b0000, 1'b0);

    // All requesters held with fresh data after each grant.
    do_reset;
    for (int i = 0; i < NREQ; i++) dat[i] = 12'($urandom);
    req = 4'b1111;
    repeat (6) do_txn(int'($urandom_range(0, 4)), int'($urandom_range(3, 8)), 4'b0000, 1'b1);
    req = '0;
    tick;

    // Request raised while busy; cs edges coincide with the timeout in both phases.
    dat[0] = 12'h3C3;
    dat[1] = 12'h4B4;
    req = 4'b0001;
    do_txn(14, 17, 4'b0010, 1'b0);
    do_txn(2, 5, 4'b0000, 1'b0);

    // Master never starts the frame.
    dat[1] = 12'h7E1;
    req = 4'b0010;
    w  = model_winner(req, last_id);
    ed = dat[w];
    tick;
    chk("to_l_gnt", 32'(gnt), 32'(1 << w));
    req = '0;
    ok = 1'b1;
    repeat (TIMEOUT) begin
      tick;
      if (newd !== 1'b1 || err !== 1'b0) ok = 1'b0;
    end
    chk("to_l_newd_17clk", 32'(ok), 32'd1);
    tick;
    chk("to_l_err", 32'(err), 32'd1);
    chk("to_l_err_id", 32'(err_id), 32'(w));
    chk("to_l_newd_low", 32'(newd), 32'd0);
    chk("to_l_no_cmpl", 32'(cmpl), 32'd0);
    chk("to_l_busy", 32'(busy), 32'd0);
    tick;
    chk("to_l_err_pulse", 32'(err), 32'd0);
    chk("to_l_busy_next", 32'(busy), 32'd0);
    chk("to_l_no_cmpl_next", 32'(cmpl), 32'd0);
    chk("to_l_din_held", 32'(din), 32'(ed));
    last_id = w;

    // Master starts but never ends the frame.
    dat[2] = 12'h5A6;
    req = 4'b0100;
    w  = model_winner(req, last_id);
    tick;
    chk("to_x_gnt", 32'(gnt), 32'(1 << w));
    req = '0;
    tick;
    cs = 1'b0;
    repeat (3) tick;
    chk("to_x_newd_low", 32'(newd), 32'd0);
    ok = 1'b1;
    repeat (TIMEOUT) begin
      tick;
      if (err !== 1'b0 || cmpl !== '0) ok = 1'b0;
    end
    chk("to_x_quiet", 32'(ok), 32'd1);
    tick;
    chk("to_x_err", 32'(err), 32'd1);
    chk("to_x_err_id", 32'(err_id), 32'(w));
    chk("to_x_no_cmpl", 32'(cmpl), 32'd0);
    cs = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      tick;
      if (cmpl !== '0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("to_x_after", 32'(ok), 32'd1);
    last_id = w;

    // Reset in the middle of a frame.
    dat[0] = 12'h0F0;
    req = 4'b0001;
    tick;
    chk("rst_mid_gnt", 32'(gnt), 32'd1);
    req = '0;
    cs = 1'b0;
    repeat (5) tick;
    chk("rst_mid_in_xfer", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_newd", 32'(newd), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_gnt0", 32'(gnt), 32'd0);
    chk("rst_mid_cmpl", 32'(cmpl), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    cs = 1'b1;
    tick;
    tick;
    rst = 1'b1;
    last_id = NREQ - 1;
    ok = 1'b1;
    repeat (3) begin
      tick;
      if (cmpl !== '0 || err !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rst_mid_no_cmpl", 32'(ok), 32'd1);
    dat[1] = 12'h123;
    dat[3] = 12'h999;
    req = 4'b1010;
    do_txn(1, 4, 4'b0000, 1'b0);
    do_txn(1, 4, 4'b0000, 1'b0);

    // Randomised traffic.
    repeat (25) begin
      if (req == '0) req = 4'($urandom_range(1, 15));
      do_txn(int'($urandom_range(0, 10)), int'($urandom_range(3, 17)),
             ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000,
             1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
